// File: rtl/pulse_sweep_sequencer_pkg.sv
// Shared types and width constants for the pulse sweep sequencer.
// State encoding is fixed so that a debug readout keeps its meaning.
package pulse_seq_pkg;

    localparam int unsigned TW_DEF = 32;
    localparam int unsigned NW_DEF = 16;
    localparam int unsigned SW_DEF = NW_DEF + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // Width needed to hold 2*shots_per_point without overflow.
    function automatic int unsigned shot_w(input int unsigned nw);
        return nw + 1;
    endfunction

endpackage

// File: rtl/pulse_sweep_sequencer_if.sv
// Host/generator-facing signal bundle of the sweep sequencer.
// The slave side is the sequencer; the master side is the host plus the pulse generator.
interface pulse_sweep_sequencer_if
    import pulse_seq_pkg::*;
#(
    parameter int unsigned TW = TW_DEF,
    parameter int unsigned NW = NW_DEF
);
    logic          start;
    logic          abort;
    logic          cycle_start;
    logic [TW-1:0] base_delay;
    logic [TW-1:0] delay_step;
    logic [NW-1:0] num_points;
    logic [NW-1:0] shots_per_point;
    logic          pump_en;
    logic          pump_alt;

    logic [TW-1:0] delay_out;
    logic          pump_out;
    logic [NW-1:0] point_idx;
    logic          busy;
    logic          point_done;
    logic          sweep_done;
    logic          cfg_err;

    modport slave (
        input  start, abort, cycle_start, base_delay, delay_step,
               num_points, shots_per_point, pump_en, pump_alt,
        output delay_out, pump_out, point_idx, busy,
               point_done, sweep_done, cfg_err
    );

    modport master (
        output start, abort, cycle_start, base_delay, delay_step,
               num_points, shots_per_point, pump_en, pump_alt,
        input  delay_out, pump_out, point_idx, busy,
               point_done, sweep_done, cfg_err
    );
endinterface

// File: rtl/pulse_sweep_sequencer_shot_counter.sv
// Per-point shot counter and pump toggle for the sweep sequencer.
// last_o flags that the current shot is the final one of the point.
module seq_shot_counter
    import pulse_seq_pkg::*;
#(
    parameter int unsigned SW = SW_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          advance_i,
    input  logic [SW-1:0] target_i,
    input  logic          pump_en_i,
    input  logic          pump_alt_i,
    output logic          last_o,
    output logic          pump_o
);

    logic [SW-1:0] cnt_q, cnt_d;
    logic          pump_q, pump_d;

    assign last_o = (cnt_q == (target_i - SW'(1)));
    assign pump_o = pump_q;

    always_comb begin
        cnt_d  = cnt_q;
        pump_d = pump_q;
        if (clear_i) begin
            cnt_d  = '0;
            pump_d = pump_en_i;
        end else if (advance_i && !last_o) begin
            cnt_d = cnt_q + SW'(1);
            if (pump_alt_i) begin
                pump_d = ~pump_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            pump_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pump_q <= pump_d;
        end
    end

endmodule

// File: rtl/pulse_sweep_sequencer.sv
// Echo-decay sweep sequencer: latches a sweep description, then steps the generator
// delay across N points, committing every change on the generator's period boundary.
module pulse_sweep_sequencer
    import pulse_seq_pkg::*;
#(
    parameter int unsigned TW = TW_DEF,
    parameter int unsigned NW = NW_DEF
) (
    input  logic                   clk_pll,
    input  logic                   reset,
    pulse_sweep_sequencer_if.slave bus
);

    localparam int unsigned SW = shot_w(NW);

    state_e        state_q, state_d;
    logic [TW-1:0] delay_q, delay_d;
    logic [TW-1:0] step_q, step_d;
    logic [NW-1:0] idx_q, idx_d;
    logic [NW-1:0] npts_q, npts_d;
    logic [SW-1:0] target_q, target_d;
    logic          pump_en_q, pump_en_d;
    logic          pump_alt_q, pump_alt_d;
    logic          busy_q, busy_d;
    logic          pd_q, pd_d;
    logic          sd_q, sd_d;
    logic          ce_q, ce_d;

    logic          sc_clear, sc_adv, sc_pump_en, sc_last, sc_pump;

    seq_shot_counter #(.SW(SW)) u_shot (
        .clk_i      (clk_pll),
        .rst_i      (reset),
        .clear_i    (sc_clear),
        .advance_i  (sc_adv),
        .target_i   (target_q),
        .pump_en_i  (sc_pump_en),
        .pump_alt_i (pump_alt_q),
        .last_o     (sc_last),
        .pump_o     (sc_pump)
    );

    always_comb begin
        state_d    = state_q;
        delay_d    = delay_q;
        step_d     = step_q;
        idx_d      = idx_q;
        npts_d     = npts_q;
        target_d   = target_q;
        pump_en_d  = pump_en_q;
        pump_alt_d = pump_alt_q;
        pd_d       = 1'b0;
        sd_d       = 1'b0;
        ce_d       = 1'b0;
        sc_clear   = 1'b0;
        sc_adv     = 1'b0;
        sc_pump_en = pump_en_q;

        if (bus.abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.num_points == '0 || bus.shots_per_point == '0) begin
                            ce_d = 1'b1;
                        end else begin
                            step_d     = bus.delay_step;
                            npts_d     = bus.num_points;
                            pump_en_d  = bus.pump_en;
                            pump_alt_d = bus.pump_alt;
                            target_d   = bus.pump_alt ? {bus.shots_per_point, 1'b0}
                                                      : {1'b0, bus.shots_per_point};
                            delay_d    = bus.base_delay;
                            idx_d      = '0;
                            // Shadow pump_en is not loaded yet, so seed the counter from the host.
                            sc_clear   = 1'b1;
                            sc_pump_en = bus.pump_en;
                            state_d    = ST_ARM;
                        end
                    end
                end
                ST_ARM: begin
                    if (bus.cycle_start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.cycle_start) begin
                        if (!sc_last) begin
                            sc_adv = 1'b1;
                        end else begin
                            pd_d = 1'b1;
                            if (idx_q == (npts_q - NW'(1))) begin
                                sd_d    = 1'b1;
                                state_d = ST_IDLE;
                            end else begin
                                idx_d    = idx_q + NW'(1);
                                delay_d  = delay_q + step_q;
                                sc_clear = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_pll) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            delay_q    <= '0;
            step_q     <= '0;
            idx_q      <= '0;
            npts_q     <= '0;
            target_q   <= '0;
            pump_en_q  <= 1'b0;
            pump_alt_q <= 1'b0;
            busy_q     <= 1'b0;
            pd_q       <= 1'b0;
            sd_q       <= 1'b0;
            ce_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            delay_q    <= delay_d;
            step_q     <= step_d;
            idx_q      <= idx_d;
            npts_q     <= npts_d;
            target_q   <= target_d;
            pump_en_q  <= pump_en_d;
            pump_alt_q <= pump_alt_d;
            busy_q     <= busy_d;
            pd_q       <= pd_d;
            sd_q       <= sd_d;
            ce_q       <= ce_d;
        end
    end

    assign bus.delay_out  = delay_q;
    assign bus.pump_out   = sc_pump;
    assign bus.point_idx  = idx_q;
    assign bus.busy       = busy_q;
    assign bus.point_done = pd_q;
    assign bus.sweep_done = sd_q;
    assign bus.cfg_err    = ce_q;

endmodule

// File: tb/tb_pulse_sweep_sequencer.sv
// Scoreboard bench for pulse_sweep_sequencer: directed sweeps push expected output
// snapshots; the monitor pops one whenever a strobe fires or a held output changes.
module tb_pulse_sweep_sequencer;

    localparam int unsigned TW = 32;
    localparam int unsigned NW = 16;

    typedef struct {
        logic [TW-1:0] delay;
        logic          pump;
        logic [NW-1:0] idx;
        logic          busy;
        logic          pd;
        logic          sd;
        logic          ce;
        string         name;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    pulse_sweep_sequencer_if #(.TW(TW), .NW(NW)) bus ();

    pulse_sweep_sequencer #(.TW(TW), .NW(NW)) dut (
        .clk_pll (clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [TW-1:0] d, input logic p, input logic [NW-1:0] i,
                        input logic b, input logic pd, input logic sd, input logic ce,
                        input string name);
        exp_t e;
        e.delay = d; e.pump = p; e.idx = i; e.busy = b;
        e.pd = pd; e.sd = sd; e.ce = ce; e.name = name;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic pulse_cs(input int gap);
        repeat (gap - 1) @(negedge clk);
        bus.cycle_start = 1'b1;
        @(negedge clk);
        bus.cycle_start = 1'b0;
    endtask

    task automatic setup(input logic [TW-1:0] base, input logic [TW-1:0] step,
                         input logic [NW-1:0] np, input logic [NW-1:0] sh,
                         input logic pen, input logic alt);
        bus.base_delay = base; bus.delay_step = step;
        bus.num_points = np; bus.shots_per_point = sh;
        bus.pump_en = pen; bus.pump_alt = alt;
    endtask

    // Monitor
    initial begin
        logic [TW+NW+1:0] prev;
        logic [TW+NW+1:0] held;
        exp_t e;
        prev = '1;
        wait (mon_en);
        forever begin
            @(negedge clk);
            held = {bus.delay_out, bus.pump_out, bus.point_idx, bus.busy};
            if (bus.point_done || bus.sweep_done || bus.cfg_err || held !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got delay=%h pump=%b idx=%0d busy=%b pd=%b sd=%b ce=%b, required no event",
                             bus.delay_out, bus.pump_out, bus.point_idx, bus.busy,
                             bus.point_done, bus.sweep_done, bus.cfg_err);
                end else begin
                    e = q.pop_front();
                    if (bus.delay_out !== e.delay || bus.pump_out !== e.pump ||
                        bus.point_idx !== e.idx || bus.busy !== e.busy ||
                        bus.point_done !== e.pd || bus.sweep_done !== e.sd ||
                        bus.cfg_err !== e.ce) begin
                        errors++;
                        $display("FAIL %s: got delay=%h pump=%b idx=%0d busy=%b pd=%b sd=%b ce=%b, required delay=%h pump=%b idx=%0d busy=%b pd=%b sd=%b ce=%b",
                                 e.name, bus.delay_out, bus.pump_out, bus.point_idx, bus.busy,
                                 bus.point_done, bus.sweep_done, bus.cfg_err,
                                 e.delay, e.pump, e.idx, e.busy, e.pd, e.sd, e.ce);
                    end
                end
            end
            prev = held;
        end
    end

    // Stimulus
    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.cycle_start = 1'b0;
        setup(32'd0, 32'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        tick(2);
        push(32'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_state");
        mon_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick(2);

        // Basic sweep
        setup(32'd1000, 32'd200, 16'd3, 16'd2, 1'b0, 1'b0);
        push(32'd1000, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, "basic_load");
        pulse_start();
        pulse_cs(20);
        pulse_cs(20);
        push(32'd1200, 1'b0, 16'd1, 1'b1, 1'b1, 1'b0, 1'b0, "basic_pt0");
        pulse_cs(20);
        pulse_cs(20);
        push(32'd1400, 1'b0, 16'd2, 1'b1, 1'b1, 1'b0, 1'b0, "basic_pt1");
        pulse_cs(20);
        pulse_cs(20);
        push(32'd1400, 1'b0, 16'd2, 1'b0, 1'b1, 1'b1, 1'b0, "basic_done");
        pulse_cs(20);
        pulse_cs(5);

        // Pump alternation
        setup(32'd50, 32'd10, 16'd2, 16'd2, 1'b1, 1'b1);
        push(32'd50, 1'b1, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, "alt_load");
        pulse_start();
        pulse_cs(5);
        for (int p = 0; p < 2; p++) begin
            for (int k = 1; k < 4; k++) begin
                push(32'd50 + 32'(10 * p), (k % 2 == 0), 16'(p), 1'b1, 1'b0, 1'b0, 1'b0, "alt_shot");
                pulse_cs(5);
            end
            if (p == 0) push(32'd60, 1'b1, 16'd1, 1'b1, 1'b1, 1'b0, 1'b0, "alt_pt0");
            else        push(32'd60, 1'b0, 16'd1, 1'b0, 1'b1, 1'b1, 1'b0, "alt_done");
            pulse_cs(5);
        end
        tick(3);

        // Rejected starts
        setup(32'd7, 32'd7, 16'd0, 16'd2, 1'b1, 1'b0);
        push(32'd60, 1'b0, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1, "rej_points");
        pulse_start();
        tick(3);
        setup(32'd7, 32'd7, 16'd2, 16'd0, 1'b1, 1'b0);
        push(32'd60, 1'b0, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1, "rej_shots");
        pulse_start();
        tick(3);

        // Abort simultaneous with cycle_start, plus start while busy
        setup(32'd100, 32'd5, 16'd3, 16'd1, 1'b0, 1'b0);
        push(32'd100, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, "abort_load");
        pulse_start();
        pulse_cs(5);
        bus.num_points = 16'd0;
        pulse_start();
        push(32'd105, 1'b0, 16'd1, 1'b1, 1'b1, 1'b0, 1'b0, "abort_pt0");
        pulse_cs(5);
        tick(4);
        push(32'd105, 1'b0, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, "abort_idle");
        bus.abort = 1'b1;
        bus.cycle_start = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.cycle_start = 1'b0;
        tick(10);

        // Host changes after start are ignored
        setup(32'd300, 32'd7, 16'd2, 16'd1, 1'b0, 1'b0);
        push(32'd300, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, "latch_load");
        pulse_start();
        setup(32'd0, 32'd1000, 16'd9, 16'd4, 1'b1, 1'b1);
        pulse_cs(5);
        push(32'd307, 1'b0, 16'd1, 1'b1, 1'b1, 1'b0, 1'b0, "latch_pt0");
        pulse_cs(5);
        push(32'd307, 1'b0, 16'd1, 1'b0, 1'b1, 1'b1, 1'b0, "latch_done");
        pulse_cs(5);
        tick(3);

        // Delay wrap
        setup(32'hFFFF_FF00, 32'h0000_0200, 16'd2, 16'd1, 1'b0, 1'b0);
        push(32'hFFFF_FF00, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, "wrap_load");
        pulse_start();
        pulse_cs(5);
        push(32'h0000_0100, 1'b0, 16'd1, 1'b1, 1'b1, 1'b0, 1'b0, "wrap_pt0");
        pulse_cs(5);
        push(32'h0000_0100, 1'b0, 16'd1, 1'b0, 1'b1, 1'b1, 1'b0, "wrap_done");
        pulse_cs(5);
        tick(3);

        // Reset mid-sweep
        setup(32'd500, 32'd1, 16'd5, 16'd1, 1'b1, 1'b0);
        push(32'd500, 1'b1, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, "rst_load");
        pulse_start();
        pulse_cs(5);
        push(32'd501, 1'b1, 16'd1, 1'b1, 1'b1, 1'b0, 1'b0, "rst_pt0");
        pulse_cs(5);
        tick(2);
        push(32'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_mid");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pulse_cs(5);
        tick(5);

        for (int n = 0; n < 50 && q.size() != 0; n++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected events, required 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_sweep_sequencer.md
# pulse_sweep_sequencer

Sequencer that drives the delay and pump controls of the pulse generator through an automated echo-decay sweep. It latches a sweep description from the host, fires a programmable number of shots at each delay point, and steps the delay linearly across N points. Parameter changes are committed only at the generator's period boundary, so each shot is generated with one consistent configuration. It sits between the host register block and the pulse generator's `delay`/`pump` inputs.

## Interface
- `TW`, 32, width of time quantities in 200 MHz clock ticks.
- `NW`, 16, width of the point-count and shot-count fields.
- `clk_pll`  in  1  200 MHz PLL clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a sweep.
- `abort`  in  1  one-cycle request to stop the sweep.
- `cycle_start`  in  1  one-cycle strobe from the pulse generator, high on the last tick of each period (counter == period).
- `base_delay`  in  TW  delay at point 0.
- `delay_step`  in  TW  delay increment per point.
- `num_points`  in  NW  number of delay points.
- `shots_per_point`  in  NW  shots per point.
- `pump_en`  in  1  pump setting at the start of each point.
- `pump_alt`  in  1  when 1, pump toggles every shot and the shot count doubles (on/off background subtraction).
- `delay_out`  out  TW  to the generator `delay` input.
- `pump_out`  out  1  to the generator `pump` input.
- `point_idx`  out  NW  current point index.
- `busy`  out  1  high in ARM and RUN.
- `point_done`  out  1  one-cycle strobe at the end of each point.
- `sweep_done`  out  1  one-cycle strobe at the end of the last point.
- `cfg_err`  out  1  one-cycle strobe when `start` is rejected.

## Operation
- States: IDLE, ARM, RUN.
- **IDLE**
  - On `start`, latch all sweep inputs into shadow registers. Host changes after this have no effect until the next `start`.
  - After latching, set `delay_out`=base_delay, `pump_out`=pump_en, `point_idx`=0, shot counter=0, then go to ARM.
  - If the latched `num_points`==0 or `shots_per_point`==0, stay in IDLE and pulse `cfg_err` instead.
- **ARM**
  - Wait for `cycle_start`, then go to RUN.
  - The period that begins after this strobe is shot 0.
- **RUN**
  - Each `cycle_start` completes one shot.
  - Effective shot target S = shots_per_point, or 2×shots_per_point when `pump_alt`=1. Compute in NW+1 bits with no overflow.
  - If shot counter < S−1:
    - Increment the shot counter.
    - If `pump_alt`=1, toggle `pump_out`.
  - Otherwise, end the point:
    - Pulse `point_done`.
    - If `point_idx`==num_points−1, pulse `sweep_done` in the same cycle and go to IDLE. Outputs hold their last values.
    - Otherwise increment `point_idx`, set `delay_out` ← `delay_out`+delay_step (modulo 2^TW, wraps), shot counter=0, `pump_out`=pump_en.
- **Abort and `start` priority**
  - `abort` in any state sends the FSM to IDLE on the next edge. Outputs hold, `busy` drops, and no done strobes fire.
  - `abort` wins over a simultaneous `cycle_start` or `start`.
  - `start` while `busy` is ignored and does not pulse `cfg_err`.
- **Reset** (synchronous, overrides everything, including mid-sweep)
  - State=IDLE.
  - `delay_out`=0, `pump_out`=0, `point_idx`=0, `busy`=0.
  - `point_done`, `sweep_done`, `cfg_err` = 0.
  - Shot counter and shadow registers = 0.

## Timing
- All outputs are registered.
- `start` to `busy`=1: 1 cycle. `delay_out`, `pump_out` and `point_idx` load in that same cycle.
- `cycle_start` in RUN → updated `delay_out`/`pump_out`/`point_idx` on the next edge. Updates are therefore valid when the generator counter equals 0, before the generator samples them at counter<2.
- `point_done` and `sweep_done` are high during the cycle after the qualifying `cycle_start`, coincident with the output update.
- `busy` falls in the same cycle that `sweep_done` is high.
- `cycle_start` in IDLE is ignored.
- Consecutive `cycle_start` strobes are guaranteed at least 3 cycles apart (period ≥ 2). The block must not rely on a larger gap.
- A `start` arriving in the same cycle as `sweep_done` is accepted (state is already IDLE on that edge only if `busy`=0). Otherwise it is ignored per the rule above.

## Structure
- Package `pulse_seq_pkg`:
  - state encoding (IDLE=0, ARM=1, RUN=2);
  - `TW`/`NW` defaults;
  - shot-target width constant NW+1.
- One natural sub-module: `seq_shot_counter`.
  - Holds the shot counter and the pump toggle.
  - Inputs: clear, advance, latched S, pump_en, pump_alt.
  - Outputs: last-shot flag, pump.
  - The top level holds the FSM, the delay accumulator and the point index.

## Test plan
- **Basic sweep.** base=1000, step=200, points=3, shots=2, alt=0, `cycle_start` every 20 cycles.
  - `delay_out` sequence 1000,1000,1000→1200→1400 across strobes (the 1000,1000 entries are the `start` load and the ARM→RUN strobe).
  - `point_done`×3, `sweep_done` once, `busy` low after the 7th `cycle_start` (1 ARM + 6 shots).
- **Pump alternation.** shots=2, alt=1, pump_en=1.
  - `pump_out` sequence 1,0,1,0 per point; 4 shots per point; `pump_out` returns to 1 at the next point.
- **Rejected start.** points=0 → `cfg_err` pulse, `busy` stays 0. Repeat with shots=0 → same result.
- **Abort.** Abort mid-RUN at point 1, simultaneous with `cycle_start` → IDLE next cycle, `point_idx` holds 1, no `point_done` or `sweep_done`.
- **Latch and reset.** Change `delay_step` mid-sweep → no effect on `delay_out`. Assert `reset` mid-sweep → all outputs 0 next cycle.
- **Delay wrap.** base=0xFFFF_FF00, step=0x200 → second point `delay_out`=0x0000_0100.
